ipsxe_floating_point_apm_mult_addsub_pipe_v1_0: RTL

//  Parametrised pipelined APM datapath: o_p = i_z +/- (i_x * i_y), selectable per operation.

---
 rtl/ipsxe_floating_point_apm_mult_addsub_pipe_v1_0_pkg.sv | 7 +
 rtl/ipsxe_floating_point_apm_pipe_reg_v1_0.sv | 21 ++
 rtl/ipsxe_floating_point_apm_mult_addsub_pipe_v1_0.sv | 91 +++++++++
 3 files changed

// File: rtl/ipsxe_floating_point_apm_mult_addsub_pipe_v1_0_pkg.sv
// ipsxe_floating_point_apm_mult_addsub_pipe_v1_0_pkg: pipeline stage ids and LATENCY-to-stage mapping
package ipsxe_floating_point_apm_mult_addsub_pipe_v1_0_pkg;
  typedef enum logic [1:0] {ST_IN, ST_M, ST_P} stage_e;
  function automatic bit stage_present(int latency, stage_e s);
    return s == ST_P || (s == ST_M && latency >= 2) || (s == ST_IN && latency == 3);
  endfunction
endpackage

// File: rtl/ipsxe_floating_point_apm_pipe_reg_v1_0.sv
// ipsxe_floating_point_apm_pipe_reg_v1_0: enable-gated sync-reset register, or a plain wire when not present
module ipsxe_floating_point_apm_pipe_reg_v1_0 #(
  parameter int WIDTH   = 1,
  parameter bit PRESENT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (PRESENT) begin : g_reg
    always_ff @(posedge clk)
      if (!rst_n) q <= '0;
      else if (ce) q <= d;
  end else begin : g_wire
    logic unused_ctl;
    assign unused_ctl = &{1'b0, clk, rst_n, ce};
    assign q = d;
  end
endmodule

// File: rtl/ipsxe_floating_point_apm_mult_addsub_pipe_v1_0.sv
// ipsxe_floating_point_apm_mult_addsub_pipe_v1_0: pipelined o_p = z +/- x*y with valid/tag side-band and clock enable
// Define IPSXE_FLOATING_POINT_APM_SAT_EN to saturate out-of-range results and raise o_ovf.
module ipsxe_floating_point_apm_mult_addsub_pipe_v1_0
  import ipsxe_floating_point_apm_mult_addsub_pipe_v1_0_pkg::*;
#(
  parameter int X_WIDTH   = 25,
  parameter int Y_WIDTH   = 18,
  parameter int Z_WIDTH   = 48,
  parameter int P_WIDTH   = 48,
  parameter int SIGNED    = 0,
  parameter int LATENCY   = 2,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_ce,
  input  logic                 i_valid,
  input  logic                 i_sub,
  input  logic [X_WIDTH-1:0]   i_x,
  input  logic [Y_WIDTH-1:0]   i_y,
  input  logic [Z_WIDTH-1:0]   i_z,
  input  logic [TAG_WIDTH-1:0] i_tag,
  output logic                 o_valid,
  output logic [P_WIDTH-1:0]   o_p,
  output logic [TAG_WIDTH-1:0] o_tag,
  output logic                 o_ovf
);
  localparam int M_W = X_WIDTH + Y_WIDTH;
  localparam int C_W = 1 + TAG_WIDTH;
  localparam bit SG  = SIGNED != 0;
`ifdef IPSXE_FLOATING_POINT_APM_SAT_EN
  // Wide enough that neither operand nor the sum wraps, so the range check sees the true value
  localparam int A_W = M_W > Z_WIDTH ? M_W : Z_WIDTH;
  localparam int E_W = (A_W > P_WIDTH ? A_W : P_WIDTH) + 2;
  localparam logic [P_WIDTH-1:0] P_MIN = {1'b1, {(P_WIDTH-1){1'b0}}};
  localparam logic [P_WIDTH-1:0] P_MAX = ~P_MIN;
`else
  localparam int E_W = P_WIDTH;
`endif
  if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
    $error("LATENCY must be in 1..3");
  end
  logic [X_WIDTH-1:0] a_x;
  logic [Y_WIDTH-1:0] a_y;
  logic [Z_WIDTH-1:0] a_z, m_z;
  logic               a_sub, m_sub;
  logic [C_W-1:0]     a_c, m_c;
  logic [M_W-1:0]     a_prod, m_prod;
  logic [E_W-1:0]     m_ze, m_pe, m_sum;
  logic [P_WIDTH-1:0] m_res;
  ipsxe_floating_point_apm_pipe_reg_v1_0 #(.WIDTH(M_W + Z_WIDTH + 1), .PRESENT(stage_present(LATENCY, ST_IN))) u_in_d (
    .clk(i_clk), .rst_n(i_rst_n), .ce(i_ce), .d({i_x, i_y, i_z, i_sub}), .q({a_x, a_y, a_z, a_sub})
  );
  ipsxe_floating_point_apm_pipe_reg_v1_0 #(.WIDTH(C_W), .PRESENT(stage_present(LATENCY, ST_IN))) u_in_c (
    .clk(i_clk), .rst_n(i_rst_n), .ce(i_ce), .d({i_valid, i_tag}), .q(a_c)
  );
  always_comb a_prod = (SG ? M_W'($signed(a_x)) : M_W'(a_x)) * (SG ? M_W'($signed(a_y)) : M_W'(a_y));
  ipsxe_floating_point_apm_pipe_reg_v1_0 #(.WIDTH(M_W + Z_WIDTH + 1), .PRESENT(stage_present(LATENCY, ST_M))) u_m_d (
    .clk(i_clk), .rst_n(i_rst_n), .ce(i_ce), .d({a_prod, a_z, a_sub}), .q({m_prod, m_z, m_sub})
  );
  ipsxe_floating_point_apm_pipe_reg_v1_0 #(.WIDTH(C_W), .PRESENT(stage_present(LATENCY, ST_M))) u_m_c (
    .clk(i_clk), .rst_n(i_rst_n), .ce(i_ce), .d(a_c), .q(m_c)
  );
`ifdef IPSXE_FLOATING_POINT_APM_SAT_EN
  logic m_ovf;
`endif
  always_comb begin
    m_ze  = SG ? E_W'($signed(m_z)) : E_W'(m_z);
    m_pe  = SG ? E_W'($signed(m_prod)) : E_W'(m_prod);
    m_sum = m_sub ? m_ze - m_pe : m_ze + m_pe;
`ifdef IPSXE_FLOATING_POINT_APM_SAT_EN
    m_ovf = SG ? (|m_sum[E_W-1:P_WIDTH-1] && !(&m_sum[E_W-1:P_WIDTH-1])) : |m_sum[E_W-1:P_WIDTH];
    m_res = !m_ovf ? m_sum[P_WIDTH-1:0] : m_sum[E_W-1] ? (SG ? P_MIN : '0) : (SG ? P_MAX : '1);
`else
    m_res = m_sum;
`endif
  end
  ipsxe_floating_point_apm_pipe_reg_v1_0 #(.WIDTH(P_WIDTH), .PRESENT(1'b1)) u_p_d (
    .clk(i_clk), .rst_n(i_rst_n), .ce(i_ce), .d(m_res), .q(o_p)
  );
  ipsxe_floating_point_apm_pipe_reg_v1_0 #(.WIDTH(C_W), .PRESENT(1'b1)) u_p_c (
    .clk(i_clk), .rst_n(i_rst_n), .ce(i_ce), .d(m_c), .q({o_valid, o_tag})
  );
`ifdef IPSXE_FLOATING_POINT_APM_SAT_EN
  ipsxe_floating_point_apm_pipe_reg_v1_0 #(.WIDTH(1), .PRESENT(1'b1)) u_p_o (
    .clk(i_clk), .rst_n(i_rst_n), .ce(i_ce), .d(m_ovf), .q(o_ovf)
  );
`else
  assign o_ovf = 1'b0;
`endif
endmodule
